if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage at the front of pipeline_RISCV.
- Holds the PC and a byte-addressed, little-endian instruction memory. The memory is preloaded through a word-write port, which is the path the bench uses for instructions.hex.
- Registers {pc, instr, valid} into the IF/ID pipeline register that the decode stage consumes.
- Honours decode-stage stall requests and execute-stage branch/jump redirects.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes; power of two, at least 8.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, PC and instruction width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset (sampled on the clk rising edge).
- stall  in  1  hazard unit: hold PC and IF/ID.
- redirect_valid  in  1  taken branch/jump resolved downstream.
- redirect_pc  in  XLEN  target PC for the redirect.
- load_en  in  1  instruction-memory word write strobe.
- load_addr  in  XLEN  byte address of the write; bits [1:0] ignored.
- load_data  in  32  instruction word, stored little-endian.
- pc  out  XLEN  current fetch PC.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  XLEN  PC of the registered instruction.
- if_id_instr  out  32  registered instruction.
- if_id_fault  out  1  fetch fault flag (see Optional Feature).

Behaviour:
- Reset values:
  - pc = RESET_PC.
  - if_id_valid = 0.
  - if_id_pc = 0.
  - if_id_instr = 32'h0000_0013 (NOP).
  - if_id_fault = 0.
  - Memory contents are not cleared.
- Memory read is combinational at idx = pc mod IMEM_BYTES.
  - instr = {mem[idx+3], mem[idx+2], mem[idx+1], mem[idx]}.
  - Each byte index wraps mod IMEM_BYTES.
- Memory write, when load_en is set:
  - Writes mem[a..a+3] = load_data[7:0], [15:8], [23:16], [31:24], where a = {load_addr[..:2], 2'b00} mod IMEM_BYTES.
  - The write is applied whether or not reset is asserted.
- Read/write collision: a fetch in the same cycle as a write to the same word returns the old data. The new data is visible the next cycle.
- Priority per edge, highest first: reset > redirect_valid > stall > advance.
- Advance:
  - if_id_pc <= pc, if_id_instr <= instr, if_id_valid <= 1.
  - pc <= pc + 4, wrapping modulo 2^XLEN.
- Stall:
  - pc and all IF/ID outputs hold their values.
  - Stall with reset: reset wins.
- Redirect:
  - pc <= redirect_pc.
  - IF/ID becomes a bubble: valid 0, instr NOP, pc 0.
  - Redirect wins over a simultaneous stall. The wrong-path fetch is squashed.
- Latency: the word at PC X appears on if_id_* exactly one cycle after pc == X, provided there is no stall or redirect.
- After a redirect: the first target instruction is valid 2 edges after redirect_valid is sampled (one bubble cycle).
- Reset mid-stream: the in-flight IF/ID contents are discarded. Fetch restarts from RESET_PC on the cycle after reset deasserts.

Optional Feature:
- Macro: IF_FAULT_EN.
- Defined:
  - A fetch faults when pc[1:0] != 0 or pc >= IMEM_BYTES.
  - On advance with a fault: if_id_fault <= 1, if_id_instr <= NOP, if_id_valid <= 1, if_id_pc <= faulting pc.
  - pc still advances by 4.
  - Bubbles clear the fault flag.
- Undefined: if_id_fault is tied to 0, and every fetch uses the wrapped byte index with no check.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN.
  - NOP_INSTR = 32'h0000_0013.
  - Default RESET_PC.
  - The IF/ID field struct/widths that the decode stage also imports.
- Sub-module imem_bytes holds the byte array:
  - Parameter IMEM_BYTES.
  - Little-endian word write port.
  - Combinational wrapped word read port.
- if_stage holds the PC, priority logic, IF/ID register and fault logic.

Test Plan:
1. Load words 0x00500093, 0x00A00113, 0x002081B3 at addresses 0, 4, 8; release reset. Expect if_id_instr of 0x00500093, 0x00A00113, 0x002081B3 on consecutive cycles with if_id_pc 0, 4, 8. Expect memory bytes 0x93, 0x00, 0x50, 0x00 at 0..3.
2. Assert stall for 3 cycles while pc = 8. Expect pc to stay at 8 and if_id to keep pc 4 / 0x00A00113 for all 3 cycles; fetch resumes with pc 8 after release.
3. Pulse redirect_valid with redirect_pc = 0x20 and stall = 1 in the same cycle. Expect the next cycle to show pc = 0x20 and if_id_valid = 0 with instr NOP. Expect the cycle after to show if_id_pc = 0x20 with valid = 1.
4. Assert reset for 1 cycle while pc = 0x14. Expect pc = RESET_PC and valid = 0 next cycle. Memory still holds the test-1 words.
5. With IMEM_BYTES = 1024, redirect to 0x3FC. Expect the word at 0x3FC to be fetched, then pc = 0x400. Expect fault = 1 with IF_FAULT_EN defined; expect the wrapped word at 0x000 with fault = 0 without it.
6. load_en to address 0x8 in the same cycle that pc = 0x8. Expect if_id_instr to carry the old word. A later redirect to 0x8 fetches the new word.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types for the front of pipeline_RISCV: widths, NOP encoding, IF/ID record.
// No logic, so no latency and no backpressure.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Field layout of the IF/ID register, also consumed by decode.
  typedef struct packed {
    logic            valid;
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, fault: 1'b0, pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/if_stage_if.sv
// Control, preload and IF/ID signals between the fetch stage and its neighbours.
// Pure wiring, so no latency and no backpressure of its own.
interface if_stage_if #(
  parameter int XLEN = riscv_pkg::XLEN
);

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            load_en;
  logic [XLEN-1:0] load_addr;
  logic [31:0]     load_data;
  logic [XLEN-1:0] pc;
  logic            if_id_valid;
  logic [XLEN-1:0] if_id_pc;
  logic [31:0]     if_id_instr;
  logic            if_id_fault;

  modport master (
    output stall, redirect_valid, redirect_pc, load_en, load_addr, load_data,
    input  pc, if_id_valid, if_id_pc, if_id_instr, if_id_fault
  );

  modport slave (
    input  stall, redirect_valid, redirect_pc, load_en, load_addr, load_data,
    output pc, if_id_valid, if_id_pc, if_id_instr, if_id_fault
  );

endinterface

// File: rtl/imem_bytes.sv
// Byte-addressed little-endian instruction memory: word write port, unaligned wrapped word read.
// Read is combinational; write lands on the clock edge, so a same-cycle read sees old data. No backpressure.
module imem_bytes #(
  parameter  int IMEM_BYTES = 1024,
  localparam int AW         = $clog2(IMEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-3:0] waddr_word,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0]    mem [IMEM_BYTES];
  logic [AW-1:0] r1, r2, r3;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[{waddr_word, 2'b00}] <= wdata[7:0];
      mem[{waddr_word, 2'b01}] <= wdata[15:8];
      mem[{waddr_word, 2'b10}] <= wdata[23:16];
      mem[{waddr_word, 2'b11}] <= wdata[31:24];
    end
  end

  // AW-bit sums wrap naturally at the end of the array.
  assign r1 = raddr + AW'(1);
  assign r2 = raddr + AW'(2);
  assign r3 = raddr + AW'(3);

  assign rdata = {mem[r3], mem[r2], mem[r1], mem[raddr]};

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, instruction memory and IF/ID register; optional fault check under IF_FAULT_EN.
// Fetched word reaches IF/ID one cycle after pc points at it; stall holds everything, redirect squashes to a bubble.
module if_stage #(
  parameter int              XLEN       = riscv_pkg::XLEN,
  parameter int              IMEM_BYTES = 1024,
  parameter logic [XLEN-1:0] RESET_PC   = riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  if_stage_if.slave  bus
);
  import riscv_pkg::*;

  localparam int AW = $clog2(IMEM_BYTES);

  logic [XLEN-1:0] pc_q;
  if_id_t          if_id_q;
  logic [31:0]     fetch_word;
  logic            fetch_fault;
  logic            unused_bits;

  imem_bytes #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_imem (
    .clk        (clk),
    .we         (bus.load_en),
    .waddr_word (bus.load_addr[AW-1:2]),
    .wdata      (bus.load_data),
    .raddr      (pc_q[AW-1:0]),
    .rdata      (fetch_word)
  );

`ifdef IF_FAULT_EN
  assign fetch_fault = (pc_q[1:0] != 2'b00) || (pc_q >= XLEN'(IMEM_BYTES));
`else
  assign fetch_fault = 1'b0;
`endif

  assign unused_bits = ^{bus.load_addr[XLEN-1:AW], bus.load_addr[1:0], pc_q[XLEN-1:AW]};

  // Priority: reset, then redirect (kills the wrong-path fetch even when stalled), then stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= IF_ID_BUBBLE;
    end else if (bus.redirect_valid) begin
      pc_q    <= bus.redirect_pc;
      if_id_q <= IF_ID_BUBBLE;
    end else if (!bus.stall) begin
      pc_q          <= pc_q + XLEN'(4);
      if_id_q.valid <= 1'b1;
      if_id_q.fault <= fetch_fault;
      if_id_q.pc    <= pc_q;
      if_id_q.instr <= fetch_fault ? NOP_INSTR : fetch_word;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.if_id_valid = if_id_q.valid;
  assign bus.if_id_pc    = if_id_q.pc;
  assign bus.if_id_instr = if_id_q.instr;
  assign bus.if_id_fault = if_id_q.fault;

endmodule
